// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared FSM state type and select/boundary helpers for the ratio-switching divider
package clkdiv_pkg;
  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;
  localparam int SEL_W_DEF = 2;
  function automatic int clamp_sel(input int s, input int cnt_w);
    return s >= cnt_w ? cnt_w - 1 : s;
  endfunction
  function automatic logic [31:0] lo_mask(input int k);
    return (32'd2 << k) - 32'd1;
  endfunction
  function automatic logic at_boundary(input logic [31:0] cnt, input int k);
    return &(cnt | ~lo_mask(k));
  endfunction
endpackage

// File: rtl/clkdiv_counter.sv
// clkdiv_counter: free-running divide counter with registered div_out/clk_en for the next select
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_next,
  output logic [CNT_W-1:0] cnt,
  output logic             div_out,
  output logic             clk_en
);
  logic [CNT_W-1:0] cnt_n;
  assign cnt_n = cnt + CNT_W'(1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      div_out <= 1'b0;
      clk_en  <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      div_out <= cnt_n[sel_next];
      clk_en  <= (32'(cnt_n) & lo_mask(int'(sel_next))) == (32'd1 << sel_next);
    end
  end
endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// clkdiv_ratio_ctrl: power-of-two clock divider with glitch-free req/ack ratio switching
// Optional CLKDIV_SWCNT_EN adds a saturating sw_count of applied ratio changes.
module clkdiv_ratio_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int DEFAULT_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_req,
  input  logic [SEL_W-1:0] sel_in,
  output logic             sel_ack,
  output logic             busy,
  output logic             req_drop,
  output logic [SEL_W-1:0] cur_sel,
  output logic             div_out,
`ifdef CLKDIV_SWCNT_EN
  output logic [7:0]       sw_count,
`endif
  output logic             clk_en
);
  state_t           state, state_n;
  logic [SEL_W-1:0] pend_sel, pend_n, cur_n, sel_c, k;
  logic [CNT_W-1:0] cnt;
  logic             bnd;
  assign sel_c   = SEL_W'(clamp_sel(int'(sel_in), CNT_W));
  assign k       = cur_sel > pend_sel ? cur_sel : pend_sel;
  // both old and new output bits fall together when cnt[k:0] wraps
  assign bnd     = at_boundary(32'(cnt), int'(k));
  assign busy    = state != IDLE;
  assign sel_ack = state == ACK;
  always_comb begin
    state_n = state;
    pend_n  = pend_sel;
    cur_n   = cur_sel;
    case (state)
      IDLE: if (sel_req) begin
        pend_n  = sel_c;
        state_n = sel_c == cur_sel ? ACK : PEND;
      end
      PEND: if (bnd) begin
        cur_n   = pend_sel;
        state_n = ACK;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pend_sel <= SEL_W'(DEFAULT_SEL);
      cur_sel  <= SEL_W'(DEFAULT_SEL);
      req_drop <= 1'b0;
    end else begin
      state    <= state_n;
      pend_sel <= pend_n;
      cur_sel  <= cur_n;
      req_drop <= sel_req && busy;
    end
  end
`ifdef CLKDIV_SWCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sw_count <= 8'd0;
    else if (state == PEND && state_n == ACK && sw_count != 8'hff) sw_count <= sw_count + 8'd1;
  end
`endif
  clkdiv_counter #(.CNT_W(CNT_W), .SEL_W(SEL_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .sel_next(cur_n),
    .cnt     (cnt),
    .div_out (div_out),
    .clk_en  (clk_en)
  );
endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// tb_clkdiv_ratio_ctrl: schedule-based model of the divider checked every cycle, plus directed literal checks
module tb_clkdiv_ratio_ctrl;
  logic       clk = 0, rst = 0, sel_req = 0;
  logic [1:0] sel_in = 0;
  logic       sel_ack, busy, req_drop, div_out, clk_en;
  logic [1:0] cur_sel;
`ifdef CLKDIV_SWCNT_EN
  logic [7:0] sw_count;
`endif
  int tests = 0, fails = 0;
  int mn = 0, mcur = 0, rq_t = -100, ack_t = -100, drop_t = -100, sw_t = -100, nsel = 0, msw = 0;
  bit chk_on = 0;
  int lat, p, na, nd;

  always #5 clk = ~clk;

  clkdiv_ratio_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .sel_req (sel_req),
    .sel_in  (sel_in),
    .sel_ack (sel_ack),
    .busy    (busy),
    .req_drop(req_drop),
    .cur_sel (cur_sel),
    .div_out (div_out),
`ifdef CLKDIV_SWCNT_EN
    .sw_count(sw_count),
`endif
    .clk_en  (clk_en)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: mn = cycles since reset; each accepted request schedules its ack/switch cycle
  initial begin
    int s, k, m, b;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mn = 0; mcur = 0; rq_t = -100; ack_t = -100; drop_t = -100; sw_t = -100; msw = 0;
      end else begin
        if (sel_req) begin
          if (mn > rq_t && mn <= ack_t) drop_t = mn + 1;
          else begin
            s = int'(sel_in) >= 4 ? 3 : int'(sel_in);
            rq_t = mn;
            if (s == mcur) ack_t = mn + 1;
            else begin
              k = s > mcur ? s : mcur;
              m = 2 << k;
              b = mn + 1;
              while (b % m != m - 1) b++;
              ack_t = b + 1; sw_t = b + 1; nsel = s;
            end
          end
        end
        mn++;
        if (mn == sw_t) begin
          mcur = nsel;
          if (msw < 255) msw++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("div_out", int'(div_out), (mn >> mcur) & 1);
      chk("clk_en", int'(clk_en), int'(mn % (2 << mcur) == (1 << mcur)));
      chk("busy", int'(busy), int'(mn > rq_t && mn <= ack_t));
      chk("sel_ack", int'(sel_ack), int'(mn == ack_t));
      chk("req_drop", int'(req_drop), int'(mn == drop_t));
      chk("cur_sel", int'(cur_sel), mcur);
`ifdef CLKDIV_SWCNT_EN
      chk("sw_count", int'(sw_count), msw);
`endif
    end
  end

  task automatic req(input int s);
    sel_req = 1;
    sel_in = 2'(s);
    @(negedge clk);
    sel_req = 0;
  endtask

  task automatic wait_ack(output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      if (sel_ack) begin
        l = i;
        break;
      end
      @(negedge clk);
    end
    if (l < 0) chk("ack_timeout", 0, 1);
  endtask

  task automatic period(output int q);
    q = -1;
    for (int i = 0; i < 40 && !clk_en; i++) @(negedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (clk_en) begin
        q = i;
        break;
      end
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_div"}, int'(div_out), 0);
    chk({tag, "_en"}, int'(clk_en), 0);
    chk({tag, "_cur"}, int'(cur_sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ack"}, int'(sel_ack), 0);
    chk({tag, "_drop"}, int'(req_drop), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    reset_check("rst0");
    chk_on = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("first_div", int'(div_out), 1);
    chk("first_en", int'(clk_en), 1);
    @(negedge clk);
    chk("second_div", int'(div_out), 0);
    chk("second_en", int'(clk_en), 0);
    // switch 0 -> 3 sampled at cnt=5: boundary at 15, ack in cycle 16
    while (mn % 16 != 5) @(negedge clk);
    req(3);
    wait_ack(lat);
    chk("lat_sel3", lat, 11);
    chk("cur_sel3", int'(cur_sel), 3);
    period(p);
    chk("period_sel3", p, 16);
    @(negedge clk);
    req(1);
    wait_ack(lat);
    chk("cur_sel1", int'(cur_sel), 1);
    @(negedge clk);
    req(1);
    wait_ack(lat);
    chk("lat_equal", lat, 1);
    @(negedge clk);
    // request during PEND is dropped, first one still completes
    req(2);
    req(0);
    chk("drop_pulse", int'(req_drop), 1);
    wait_ack(lat);
    chk("cur_after_drop", int'(cur_sel), 2);
    @(negedge clk);
    // held request: ack, drop while in ACK, then resampled as a new request
    na = 0; nd = 0;
    sel_req = 1; sel_in = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      na += int'(sel_ack);
      nd += int'(req_drop);
      if (i == 2) sel_req = 0;
    end
    chk("held_acks", na, 2);
    chk("held_drops", nd, 1);
    // reset while pending abandons the request
    req(3);
    #2 rst = 0;
    #1 reset_check("rst_pend");
    @(negedge clk);
    rst = 1;
    na = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      na += int'(sel_ack);
    end
    chk("acks_after_rst", na, 0);
    chk("cur_after_rst", int'(cur_sel), 0);
`ifdef CLKDIV_SWCNT_EN
    for (int s = 1; s <= 3; s++) begin
      req(s);
      wait_ack(lat);
      @(negedge clk);
    end
    req(3);
    wait_ack(lat);
    @(negedge clk);
    chk("sw_count3", int'(sw_count), 3);
    for (int i = 0; i < 260; i++) begin
      req(i % 2);
      wait_ack(lat);
      @(negedge clk);
    end
    chk("sw_count_sat", int'(sw_count), 255);
`endif
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clkdiv_ratio_ctrl.md
Name: clkdiv_ratio_ctrl

Overview:
- Runtime-selectable power-of-two clock divider controller.
- Owns a free-running divide counter and produces one divided output plus a matching single-cycle clock-enable pulse.
- Accepts ratio-change requests over a req/ack handshake and applies each change only at a glitch-free boundary.
- Sits between the system configuration logic and downstream consumers of slow clocks/enables.

Parameters:
- CNT_W, 4, divide counter width; ratios available are 2^(sel+1), with sel in 0..CNT_W-1.
- SEL_W, 2, width of the ratio select fields.
- DEFAULT_SEL, 0, select value loaded at reset.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- sel_req  input  1  ratio-change request, sampled only in IDLE
- sel_in  input  SEL_W  requested select; values >= CNT_W clamp to CNT_W-1
- sel_ack  output  1  one-cycle pulse: request done, new ratio active
- busy  output  1  high while state != IDLE
- req_drop  output  1  one-cycle pulse: request arrived while busy and was discarded
- cur_sel  output  SEL_W  currently applied select
- div_out  output  1  divided clock, 50% duty, period 2^(cur_sel+1) clk cycles
- clk_en  output  1  one-cycle pulse coincident with each div_out 0->1 transition

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, cur_sel=DEFAULT_SEL, div_out=0, clk_en=0, sel_ack=0, busy=0, req_drop=0, state=IDLE. Reset mid-PEND abandons the request; no sel_ack is issued.
- Counter: cnt increments by 1 every clk and wraps modulo 2^CNT_W. It is never stalled.
- Outputs are registered: div_out(next) = cnt_next[cur_sel_next]; clk_en(next) = (cnt_next[cur_sel_next:0] == 1 followed by zeros).
- Example, sel=0: div_out toggles every cycle and clk_en is high every other cycle, coincident with div_out=1.
- Boundary: k = max(cur_sel, pend_sel); the boundary is the cycle where cnt[k:0] is all ones.
  - At that edge both the old and new output bits fall to 0.
  - Result: the old high phase completes in full and the new ratio starts with a full-length low phase. No runt pulses occur.
- State IDLE:
  - sel_req=1 latches pend_sel = clamp(sel_in).
  - If pend_sel == cur_sel, go to ACK. Otherwise go to PEND.
- State PEND: at the boundary edge, cur_sel <= pend_sel and go to ACK. The wait is at most 2^(k+1) cycles.
- State ACK: sel_ack=1 for exactly this cycle, then IDLE.
- busy = (state != IDLE).
- Request latency:
  - Equal select: sel_ack is high in the cycle after the sampling edge.
  - Different select: sel_ack is high in the cycle after the boundary edge.
- sel_req=1 while busy: the request is ignored and req_drop pulses high the next cycle. There is no queuing.
- sel_req held high across the ACK->IDLE transition is resampled in IDLE and treated as a new request.

Optional Feature:
- CLKDIV_SWCNT_EN defined:
  - Adds output sw_count[7:0], reset 0.
  - Increments on every PEND->ACK transition (real ratio changes only) and saturates at 255.
  - Equal-select requests do not count.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package clkdiv_pkg holds:
  - the state enum (IDLE, PEND, ACK);
  - the SEL_W default;
  - a clamp function for sel_in;
  - the boundary-mask function (all-ones test of cnt[k:0]).
- Natural sub-module clkdiv_counter: free-running counter plus registered div_out/clk_en generation from cur_sel. The FSM and handshake stay in the top module.

Test Plan:
- Reset, then release with sel=0: div_out = 0,1,0,1…; clk_en high on every div_out=1 cycle; busy=0; cur_sel=0.
- sel_req pulse with sel_in=3 when cnt=5: busy rises; cur_sel switches at the 15->0 edge; div_out shows no high pulse shorter than 1 cycle and no low pulse shorter than 8 cycles; sel_ack pulses next cycle; afterwards period=16 with clk_en every 16 cycles.
- sel_in=cur_sel=1: sel_ack is high in the cycle after sampling; cnt and div_out are undisturbed.
- Second sel_req while in PEND: req_drop pulses one cycle; the first request completes unchanged.
- rst asserted during PEND: all outputs return to reset values immediately; no sel_ack after release; cur_sel=DEFAULT_SEL.
- With CLKDIV_SWCNT_EN, 3 real switches plus 1 equal-select request: sw_count=3. Forced-saturation test: counter holds at 255.
